// File: rtl/watch_pkg.sv
// Shared types and constants for the watch set-mode front end.
package watch_pkg;

  localparam int unsigned FLD_MSEC = 0;
  localparam int unsigned FLD_SEC  = 1;
  localparam int unsigned FLD_MIN  = 2;
  localparam int unsigned FLD_HOUR = 3;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } main_st_e;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rep_st_e;

  // Width of a saturating counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// Hold-to-auto-repeat for one button: rising-edge strobe, then delayed periodic strobes.
// The strobe output is combinational; the parent registers it.
module btn_autorepeat
  import watch_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_1ms,
  input  logic btn,
  input  logic flush,
  output logic strobe,
  output logic busy
);

  localparam int unsigned MAX_CNT = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                        : REPEAT_RATE_MS;
  localparam int unsigned CNT_W   = cnt_width(MAX_CNT);

  rep_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             rise;

  assign rise = btn & ~btn_q;
  assign busy = (state_q != RP_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    if (flush || !btn) begin
      state_d = RP_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RP_IDLE: begin
          if (rise) begin
            strobe  = 1'b1;
            state_d = RP_DELAY;
            cnt_d   = '0;
          end
        end
        RP_DELAY: begin
          if (tick_1ms) begin
            if (cnt_q >= CNT_W'(REPEAT_DELAY_MS - 1)) begin
              strobe  = 1'b1;
              state_d = RP_REPEAT;
              cnt_d   = '0;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RP_REPEAT: begin
          if (tick_1ms) begin
            if (cnt_q >= CNT_W'(REPEAT_RATE_MS - 1)) begin
              strobe = 1'b1;
              cnt_d  = '0;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = RP_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Previous level resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RP_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Set-mode front end: turns button levels into per-field enable/inc/dec/clear strobes.
// Optional inactivity timeout back to RUN: define WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned NUM_FIELDS      = 4,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned BLINK_HALF_MS   = 250
`ifdef WATCH_SET_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_MS      = 10000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_tick_1ms,
  input  logic                  i_set_sw,
  input  logic                  i_btn_r,
  input  logic                  i_btn_l,
  input  logic                  i_btn_u,
  input  logic                  i_btn_d,
  output logic [NUM_FIELDS-1:0] o_en,
  output logic                  o_inc,
  output logic                  o_dec,
  output logic                  o_clear,
  output logic                  o_blink,
  output logic                  o_set_active
);

  localparam int unsigned FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned BLINK_W = cnt_width(BLINK_HALF_MS);

  main_st_e               state_q, state_d;
  logic [FIELD_W-1:0]     field_q, field_d;
  logic                   r_q, l_q;
  logic                   r_edge, l_edge;
  logic [1:0]             sup_q, sup_d;
  logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic [NUM_FIELDS-1:0]  en_d;
  logic                   en_chg;
  logic                   in_set;
  logic                   set_req;
  logic                   timeout;
  logic                   u_strobe, u_busy, d_strobe, d_busy;
  logic                   rep_flush, d_flush;
  logic                   inc_d, dec_d, clear_d, blink_d, edit;

  assign r_edge = i_btn_r & ~r_q;
  assign l_edge = i_btn_l & ~l_q;

`ifdef WATCH_SET_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_MS);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            lock_q, lock_d;
  logic            any_btn;

  assign any_btn = i_btn_r | i_btn_l | i_btn_u | i_btn_d;
  assign set_req = i_set_sw & ~lock_q;

  // Lock holds RUN after a timeout until the switch is cycled through 0.
  always_comb begin
    to_cnt_d = to_cnt_q;
    lock_d   = lock_q;
    timeout  = 1'b0;
    if (!i_set_sw) begin
      lock_d = 1'b0;
    end
    if (state_q != ST_SET || any_btn) begin
      to_cnt_d = '0;
    end else if (i_tick_1ms) begin
      if (to_cnt_q >= TO_W'(TIMEOUT_MS - 1)) begin
        timeout  = 1'b1;
        lock_d   = 1'b1;
        to_cnt_d = '0;
      end else if (to_cnt_q != '1) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      lock_q   <= lock_d;
    end
  end
`else
  assign set_req = i_set_sw;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    unique case (state_q)
      ST_RUN: begin
        if (set_req) begin
          state_d = ST_SET;
          field_d = FIELD_W'(FLD_SEC);
        end
      end
      ST_SET: begin
        if (!i_set_sw || timeout) begin
          state_d = ST_RUN;
        end else if (r_edge) begin
          field_d = (field_q == FIELD_W'(NUM_FIELDS - 1)) ? '0 : field_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign in_set = (state_d == ST_SET);
  assign en_d   = in_set ? (NUM_FIELDS'(1) << field_d) : '0;
  assign en_chg = (en_d != o_en);

  // Repeaters idle outside SET and on a field change; u owns the pair while active.
  assign rep_flush = ~in_set | (r_edge & (u_busy | d_busy));
  assign d_flush   = rep_flush | u_busy | u_strobe;

  btn_autorepeat #(
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_MS (REPEAT_RATE_MS)
  ) u_rep_u (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_1ms(i_tick_1ms),
    .btn     (i_btn_u),
    .flush   (rep_flush),
    .strobe  (u_strobe),
    .busy    (u_busy)
  );

  btn_autorepeat #(
    .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
    .REPEAT_RATE_MS (REPEAT_RATE_MS)
  ) u_rep_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_1ms(i_tick_1ms),
    .btn     (i_btn_d),
    .flush   (d_flush),
    .strobe  (d_strobe),
    .busy    (d_busy)
  );

  assign inc_d = u_strobe;
  assign dec_d = d_strobe;

  // Downstream clear qualifies on a delayed enable, so hold off for 2 cycles after o_en moves.
  always_comb begin
    if (en_chg) begin
      sup_d = 2'd2;
    end else if (sup_q != 2'd0) begin
      sup_d = sup_q - 2'd1;
    end else begin
      sup_d = sup_q;
    end
  end

  assign clear_d = l_edge & in_set & ~en_chg & (sup_q == 2'd0);
  assign edit    = inc_d | dec_d | clear_d;

  always_comb begin
    blink_d     = o_blink;
    blink_cnt_d = blink_cnt_q;
    if (!in_set || edit) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (i_tick_1ms) begin
      if (blink_cnt_q >= BLINK_W'(BLINK_HALF_MS - 1)) begin
        blink_d     = ~o_blink;
        blink_cnt_d = '0;
      end else if (blink_cnt_q != '1) begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      field_q      <= '0;
      r_q          <= 1'b1;
      l_q          <= 1'b1;
      sup_q        <= 2'd0;
      blink_cnt_q  <= '0;
      o_en         <= '0;
      o_inc        <= 1'b0;
      o_dec        <= 1'b0;
      o_clear      <= 1'b0;
      o_blink      <= 1'b0;
      o_set_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      r_q          <= i_btn_r;
      l_q          <= i_btn_l;
      sup_q        <= sup_d;
      blink_cnt_q  <= blink_cnt_d;
      o_en         <= en_d;
      o_inc        <= inc_d;
      o_dec        <= dec_d;
      o_clear      <= clear_d;
      o_blink      <= blink_d;
      o_set_active <= in_set;
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl; strobes are scoreboarded by kind and cycle.
module tb_watch_set_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [2:0] K_INC = 3'b100;
  localparam logic [2:0] K_DEC = 3'b010;
  localparam logic [2:0] K_CLR = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       set_sw = 1'b0;
  logic       btn_r = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_u = 1'b0;
  logic       btn_d = 1'b0;
  logic [3:0] o_en;
  logic       o_inc, o_dec, o_clear, o_blink, o_set_active;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_got;
  logic [3:0]  exp_en [3] = '{4'b0100, 4'b1000, 4'b0001};

  watch_set_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick_1ms  (tick),
    .i_set_sw    (set_sw),
    .i_btn_r     (btn_r),
    .i_btn_l     (btn_l),
    .i_btn_u     (btn_u),
    .i_btn_d     (btn_d),
    .o_en        (o_en),
    .o_inc       (o_inc),
    .o_dec       (o_dec),
    .o_clear     (o_clear),
    .o_blink     (o_blink),
    .o_set_active(o_set_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick is driven at the negedge so the DUT samples it at cycles with cyc % 4 == 1.
  initial forever begin
    @(negedge clk);
    tick = (cyc % TICK_DIV == 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input logic [2:0] kind, input int unsigned c);
    exp_q.push_back({29'd0, kind, c});
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int unsigned first_tick_after(input int unsigned c);
    int unsigned t = c + 1;
    while (t % TICK_DIV != 1) t++;
    return t;
  endfunction

  function automatic logic [8:0] outs();
    return {o_en, o_inc, o_dec, o_clear, o_blink, o_set_active};
  endfunction

  always @(negedge clk) begin
    if (o_inc || o_dec || o_clear) begin
      mon_got = {29'd0, o_inc, o_dec, o_clear, cyc};
      if (exp_q.size() == 0) chk("unexpected_strobe", mon_got, 64'd0);
      else chk("strobe", mon_got, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned p, t0, s, c;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 9'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("run_en", o_en, 4'b0000);

    // Enter SET and walk the fields
    set_sw = 1'b1;
    @(negedge clk);
    chk("set_entry_en", o_en, 4'b0010);
    chk("set_active", o_set_active, 1'b1);
    for (int i = 0; i < 3; i++) begin
      btn_r = 1'b1;
      @(negedge clk);
      chk("field_advance", o_en, exp_en[i]);
      btn_r = 1'b0;
      @(negedge clk);
    end

    // Short tap on u: one strobe
    btn_u = 1'b1;
    expect_at(K_INC, cyc + 1);
    repeat (3) @(negedge clk);
    btn_u = 1'b0;
    repeat (4) @(negedge clk);

    // Hold d for 800 ticks: strobes at 0, 500, 600, 700, 800
    p = cyc;
    btn_d = 1'b1;
    expect_at(K_DEC, p + 1);
    t0 = first_tick_after(p + 1);
    expect_at(K_DEC, t0 + TICK_DIV * 499);
    expect_at(K_DEC, t0 + TICK_DIV * 599);
    expect_at(K_DEC, t0 + TICK_DIV * 699);
    expect_at(K_DEC, t0 + TICK_DIV * 799);
    wait_until(t0 + TICK_DIV * 499 - 1);
    chk("blink_on_before_repeat", o_blink, 1'b1);
    @(negedge clk);
    chk("blink_cleared_by_strobe", o_blink, 1'b0);
    s = t0 + TICK_DIV * 799;
    wait_until(s);
    btn_d = 1'b0;
    wait_until(s + TICK_DIV * 250 - 1);
    chk("blink_low_half", o_blink, 1'b0);
    @(negedge clk);
    chk("blink_toggle", o_blink, 1'b1);

    // Clear suppression: l sampled 1 and 2 cycles after o_en change is dropped
    c = cyc;
    btn_r = 1'b1;
    wait_until(c + 1);
    btn_r = 1'b0;
    btn_l = 1'b1;
    wait_until(c + 2);
    btn_l = 1'b0;
    wait_until(c + 8);
    chk("en_after_clear_a", o_en, 4'b0010);
    c = cyc;
    btn_r = 1'b1;
    wait_until(c + 1);
    btn_r = 1'b0;
    wait_until(c + 2);
    btn_l = 1'b1;
    wait_until(c + 3);
    btn_l = 1'b0;
    wait_until(c + 8);
    c = cyc;
    btn_r = 1'b1;
    wait_until(c + 1);
    btn_r = 1'b0;
    wait_until(c + 3);
    btn_l = 1'b1;
    expect_at(K_CLR, c + 4);
    wait_until(c + 4);
    btn_l = 1'b0;
    chk("en_at_clear", o_en, 4'b1000);
    repeat (4) @(negedge clk);

    // u and d together: u wins, d needs a fresh edge afterwards
    p = cyc;
    btn_u = 1'b1;
    btn_d = 1'b1;
    expect_at(K_INC, p + 1);
    wait_until(p + 3);
    btn_u = 1'b0;
    wait_until(p + 3 + TICK_DIV * 600);
    btn_d = 1'b0;
    @(negedge clk);
    btn_d = 1'b1;
    expect_at(K_DEC, cyc + 1);
    @(negedge clk);
    btn_d = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in REPEAT with u held; no strobe after release
    p = cyc;
    btn_u = 1'b1;
    expect_at(K_INC, p + 1);
    t0 = first_tick_after(p + 1);
    expect_at(K_INC, t0 + TICK_DIV * 499);
    expect_at(K_INC, t0 + TICK_DIV * 599);
    wait_until(t0 + TICK_DIV * 599 + 20);
    chk("pre_reset_en", o_en, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), 9'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_en", o_en, 4'b0010);
    p = cyc;
    wait_until(p + TICK_DIV * 700);
    btn_u = 1'b0;
    repeat (4) @(negedge clk);

    // Back to RUN; strobes gated
    set_sw = 1'b0;
    @(negedge clk);
    chk("run_en_off", o_en, 4'b0000);
    chk("run_set_active", o_set_active, 1'b0);
    btn_u = 1'b1;
    repeat (6) @(negedge clk);
    btn_u = 1'b0;
    repeat (2) @(negedge clk);

`ifdef WATCH_SET_TIMEOUT_EN
    set_sw = 1'b1;
    @(negedge clk);
    c = cyc;
    chk("to_entry_en", o_en, 4'b0010);
    t0 = first_tick_after(c);
    wait_until(t0 + TICK_DIV * 9999 - 1);
    chk("pre_timeout_en", o_en, 4'b0010);
    @(negedge clk);
    chk("timeout_en", o_en, 4'b0000);
    chk("timeout_set_active", o_set_active, 1'b0);
    repeat (20) @(negedge clk);
    chk("lockout_en", o_en, 4'b0000);
    set_sw = 1'b0;
    @(negedge clk);
    set_sw = 1'b1;
    @(negedge clk);
    chk("reenter_en", o_en, 4'b0010);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
Set-mode front end for the watch time-counter chain; sits directly upstream of the per-field tick counters.
- Converts debounced button levels plus a set-mode switch into per-field enable, inc, dec and clear strobes.
- Provides hold-to-auto-repeat on inc/dec and a blink phase that lets the display flash the selected field.

Parameters:
NUM_FIELDS, 4, number of settable fields (0=msec, 1=sec, 2=min, 3=hour).
REPEAT_DELAY_MS, 500, hold time before auto-repeat starts, in i_tick_1ms ticks.
REPEAT_RATE_MS, 100, interval between auto-repeat strobes, in i_tick_1ms ticks.
BLINK_HALF_MS, 250, half-period of o_blink, in i_tick_1ms ticks.
TIMEOUT_MS, 10000, inactivity timeout (used only with the optional feature).

Ports:
clk  in  1  system clock; the block runs on a single clock.
rst_n  in  1  reset, asynchronous, active-low.
i_tick_1ms  in  1  one-cycle 1 ms strobe.
i_set_sw  in  1  set-mode switch level (1 = SET).
i_btn_r  in  1  debounced level; next field.
i_btn_l  in  1  debounced level; clear selected field.
i_btn_u  in  1  debounced level; increment.
i_btn_d  in  1  debounced level; decrement.
o_en  out  NUM_FIELDS  one-hot selected field; all zero in RUN.
o_inc  out  1  one-cycle increment strobe.
o_dec  out  1  one-cycle decrement strobe.
o_clear  out  1  one-cycle clear strobe.
o_blink  out  1  display blank phase for the selected field.
o_set_active  out  1  high while in SET state.

Behaviour:
- Reset values: o_en=0, o_inc=0, o_dec=0, o_clear=0, o_blink=0, o_set_active=0, FSM=RUN, field index=0, all timers=0.
- Every output is registered.
- Rising-edge detect on all four button inputs. An edge is a level of 1 with a previous level of 0.

Main FSM:
- RUN -> SET on i_set_sw=1. Field index loads 1 (sec), so o_en=4'b0010 one cycle after the transition.
- SET -> RUN on i_set_sw=0. o_en, o_inc, o_dec and o_clear go to 0 in the next cycle.
- In SET, a btn_r edge advances the field index modulo NUM_FIELDS (3 -> 0).

Clear:
- A btn_l edge in SET gives an o_clear pulse 1 cycle later.
- o_clear is suppressed for 2 cycles after any o_en change, so the downstream clear qualifier on delayed enable is satisfied.
- A suppressed btn_l edge is dropped, not queued.

Inc/dec per button (btn_autorepeat instance):
- States: IDLE -> on edge, emit strobe and go to DELAY.
- DELAY: count i_tick_1ms up to REPEAT_DELAY_MS, then emit a strobe and go to REPEAT.
- REPEAT: emit a strobe every REPEAT_RATE_MS ticks.
- A release in any state returns to IDLE with the counter cleared.
- Strobe latency is 1 cycle after the edge.

Arbitration and gating:
- u and d held simultaneously: u wins. A d strobe is inhibited while u is not in IDLE.
- A btn_r edge while u or d is held resets both repeaters to IDLE.
- Strobes are gated off in RUN.

o_blink:
- Toggles every BLINK_HALF_MS ticks in SET.
- Forced to 0 and its timer cleared on RUN, and on any inc/dec/clear strobe, so the digit stays visible while it is edited.

Reset mid-operation: returns immediately to the reset values. No strobe is emitted on release of rst_n even if buttons are held; a held button needs a new edge.

Timer widths: $clog2(max param + 1). Counters saturate and never wrap.

Optional Feature:
WATCH_SET_TIMEOUT_EN:
- Defined: an inactivity counter runs on i_tick_1ms in SET and is cleared by any button edge or held repeat.
  - Reaching TIMEOUT_MS forces RUN behaviour even though i_set_sw=1.
  - The block stays in RUN until i_set_sw goes 0 then 1.
  - o_set_active drops in the same cycle as o_en.
- Undefined: SET persists indefinitely; the counter and its logic are absent.

Decomposition:
- Shared package watch_pkg:
  - field index constants FLD_MSEC=0, FLD_SEC=1, FLD_MIN=2, FLD_HOUR=3;
  - main FSM enum {ST_RUN, ST_SET};
  - repeater enum {RP_IDLE, RP_DELAY, RP_REPEAT}.
- One sub-module, btn_autorepeat: edge detect, delay/repeat timer and strobe output. It is instantiated twice (u, d) and parameterised by REPEAT_DELAY_MS and REPEAT_RATE_MS.

Test Plan:
- Reset, then i_set_sw=1 -> o_en=0010 after 1 cycle, o_set_active=1. Three btn_r edges -> o_en 0100, 1000, 0001.
- In SET, tap btn_u for 3 cycles -> exactly one o_inc, 1 cycle after the edge. Hold btn_d for 800 ms -> o_dec at 0 ms, 500 ms, 600 ms, 700 ms, 800 ms (5 pulses).
- btn_r edge, then btn_l on the very next cycle -> no o_clear. btn_l 3 cycles after the o_en change -> o_clear 1 cycle after the edge.
- btn_u and btn_d pressed on the same cycle -> o_inc only. Release u with d still held -> no o_dec until a new d edge.
- Assert rst_n=0 mid-REPEAT with btn_u held -> all outputs 0 asynchronously. After release, no o_inc while held.
- With WATCH_SET_TIMEOUT_EN, no buttons for 10000 ticks -> o_en=0 and o_set_active=0. Toggle i_set_sw 0 -> 1 -> SET re-entered, o_en=0010.
